// File: rtl/pipe_divider_if.sv
// Operand/result bundle for pipe_divider: enable, request side and result side.
// The divider sits on the slave modport, its producer/consumer on the master.
interface pipe_divider_if #(
  parameter int NUM_W = 23,
  parameter int DEN_W = 15,
  parameter int QUO_W = 11,
  parameter int TAG_W = 8
);
  logic             en;
  logic             in_valid;
  logic [NUM_W-1:0] numer;
  logic [DEN_W-1:0] denom;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic [QUO_W-1:0] quotient;
  logic             overflow;
  logic             div_zero;
  logic [TAG_W-1:0] out_tag;

  modport master (
    output en, in_valid, numer, denom, in_tag,
    input  out_valid, quotient, overflow, div_zero, out_tag
  );

  modport slave (
    input  en, in_valid, numer, denom, in_tag,
    output out_valid, quotient, overflow, div_zero, out_tag
  );
endinterface

// File: rtl/pipe_divider.sv
// Fully pipelined unsigned restoring divider: one quotient bit per stage, with
// optional round-half-up, saturation, divide-by-zero flag and a passthrough tag.
module pipe_divider #(
  parameter int NUM_W = 23,
  parameter int DEN_W = 15,
  parameter int QUO_W = 11,
  parameter int ROUND = 0,
  parameter int TAG_W = 8
) (
  input  logic          clock,
  input  logic          aclr,
  pipe_divider_if.slave bus
);
  localparam int RW = NUM_W + 1;          // rounded numerator / remainder width
  localparam int WW = NUM_W + QUO_W + 1;  // wide enough for denom << QUO_W

  logic             in_valid_r;
  logic [NUM_W-1:0] numer_r;
  logic [DEN_W-1:0] denom_r;
  logic [TAG_W-1:0] in_tag_r;

  logic [RW-1:0]    n_s;
  logic             dz_s;
  logic             ov_s;

  logic             v_r   [0:QUO_W];
  logic             dz_r  [0:QUO_W];
  logic             ov_r  [0:QUO_W];
  logic [TAG_W-1:0] tag_r [0:QUO_W];
  logic [QUO_W-1:0] q_r   [0:QUO_W];
  logic [RW-1:0]    rem_r [0:QUO_W-1];
  logic [DEN_W-1:0] d_r   [0:QUO_W-1];

  logic [WW-1:0]    div_s  [1:QUO_W];
  logic [RW-1:0]    diff_s [1:QUO_W];
  logic             take_s [1:QUO_W];
  logic [QUO_W-1:0] bit_s  [1:QUO_W];

  logic [QUO_W-1:0] quo_nxt_s;
  logic             ov_nxt_s;
  logic             dz_nxt_s;
  logic             out_valid_r;
  logic [QUO_W-1:0] quotient_r;
  logic             overflow_r;
  logic             div_zero_r;
  logic [TAG_W-1:0] out_tag_r;

  // Input capture register.
  always_ff @(posedge clock or posedge aclr) begin
    if (aclr) begin
      in_valid_r <= 1'b0;
      numer_r    <= {NUM_W{1'b0}};
      denom_r    <= {DEN_W{1'b0}};
      in_tag_r   <= {TAG_W{1'b0}};
    end else if (bus.en) begin
      in_valid_r <= bus.in_valid;
      numer_r    <= bus.numer;
      denom_r    <= bus.denom;
      in_tag_r   <= bus.in_tag;
    end
  end

  // Rounding bias and early saturation / zero-divisor detection.
  always_comb begin
    if (ROUND != 0) begin
      n_s = RW'(numer_r) + RW'({1'b0, denom_r[DEN_W-1:1]});
    end else begin
      n_s = RW'(numer_r);
    end
    dz_s = (denom_r == {DEN_W{1'b0}});
    ov_s = !dz_s && (WW'(n_s) >= (WW'(denom_r) << QUO_W));
  end

  // Restoring trial subtraction for every stage; stage k resolves bit QUO_W-k.
  always_comb begin
    for (int k = 1; k <= QUO_W; k++) begin
      div_s[k]  = WW'(d_r[k-1]) << (QUO_W - k);
      take_s[k] = (WW'(rem_r[k-1]) >= div_s[k]);
      diff_s[k] = RW'(WW'(rem_r[k-1]) - div_s[k]);
      if (take_s[k]) begin
        bit_s[k] = {{(QUO_W-1){1'b0}}, 1'b1} << (QUO_W - k);
      end else begin
        bit_s[k] = {QUO_W{1'b0}};
      end
    end
  end

  // Divider pipeline registers; the last stage drops remainder and divisor.
  always_ff @(posedge clock or posedge aclr) begin
    if (aclr) begin
      for (int k = 0; k <= QUO_W; k++) begin
        v_r[k]   <= 1'b0;
        dz_r[k]  <= 1'b0;
        ov_r[k]  <= 1'b0;
        tag_r[k] <= {TAG_W{1'b0}};
        q_r[k]   <= {QUO_W{1'b0}};
      end
      for (int k = 0; k < QUO_W; k++) begin
        rem_r[k] <= {RW{1'b0}};
        d_r[k]   <= {DEN_W{1'b0}};
      end
    end else if (bus.en) begin
      v_r[0]   <= in_valid_r;
      dz_r[0]  <= dz_s;
      ov_r[0]  <= ov_s;
      tag_r[0] <= in_tag_r;
      q_r[0]   <= {QUO_W{1'b0}};
      rem_r[0] <= n_s;
      d_r[0]   <= denom_r;
      for (int k = 1; k <= QUO_W; k++) begin
        v_r[k]   <= v_r[k-1];
        dz_r[k]  <= dz_r[k-1];
        ov_r[k]  <= ov_r[k-1];
        tag_r[k] <= tag_r[k-1];
        q_r[k]   <= q_r[k-1] | bit_s[k];
      end
      for (int k = 1; k < QUO_W; k++) begin
        rem_r[k] <= take_s[k] ? diff_s[k] : rem_r[k-1];
        d_r[k]   <= d_r[k-1];
      end
    end
  end

  // Saturation select: zero divisor wins over overflow.
  always_comb begin
    quo_nxt_s = q_r[QUO_W];
    ov_nxt_s  = 1'b0;
    dz_nxt_s  = 1'b0;
    if (dz_r[QUO_W]) begin
      quo_nxt_s = {QUO_W{1'b1}};
      dz_nxt_s  = 1'b1;
    end else if (ov_r[QUO_W]) begin
      quo_nxt_s = {QUO_W{1'b1}};
      ov_nxt_s  = 1'b1;
    end else begin
      quo_nxt_s = q_r[QUO_W];
    end
  end

  // Output register.
  always_ff @(posedge clock or posedge aclr) begin
    if (aclr) begin
      out_valid_r <= 1'b0;
      quotient_r  <= {QUO_W{1'b0}};
      overflow_r  <= 1'b0;
      div_zero_r  <= 1'b0;
      out_tag_r   <= {TAG_W{1'b0}};
    end else if (bus.en) begin
      out_valid_r <= v_r[QUO_W];
      quotient_r  <= quo_nxt_s;
      overflow_r  <= ov_nxt_s;
      div_zero_r  <= dz_nxt_s;
      out_tag_r   <= tag_r[QUO_W];
    end
  end

  assign bus.out_valid = out_valid_r;
  assign bus.quotient  = quotient_r;
  assign bus.overflow  = overflow_r;
  assign bus.div_zero  = div_zero_r;
  assign bus.out_tag   = out_tag_r;
endmodule

// File: tb/tb_pipe_divider.sv
// Directed bench for pipe_divider: one floor instance and one round-half-up
// instance driven with identical stimulus.
module tb_pipe_divider;
  logic clock;
  logic aclr;
  int   checks;
  int   failures;

  pipe_divider_if #(.NUM_W(23), .DEN_W(15), .QUO_W(11), .TAG_W(8)) bus0 ();
  pipe_divider_if #(.NUM_W(23), .DEN_W(15), .QUO_W(11), .TAG_W(8)) bus1 ();

  pipe_divider #(.NUM_W(23), .DEN_W(15), .QUO_W(11), .ROUND(0), .TAG_W(8)) dut0 (
    .clock(clock), .aclr(aclr), .bus(bus0)
  );
  pipe_divider #(.NUM_W(23), .DEN_W(15), .QUO_W(11), .ROUND(1), .TAG_W(8)) dut1 (
    .clock(clock), .aclr(aclr), .bus(bus1)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // observation layout: {out_valid, div_zero, overflow, quotient[10:0], out_tag[7:0]}
  logic [21:0] obs0, obs1, exp0, exp1;
  logic        early0, early1;

  logic [22:0] n_a [100];
  logic [14:0] d_a [100];

  // {dz, ov, q} with saturation, from plain integer division
  function automatic logic [12:0] golden(input logic [22:0] n, input logic [14:0] d, input int rnd);
    longint unsigned nn, qq;
    nn = longint'(n) + ((rnd != 0) ? longint'(d >> 1) : 64'd0);
    if (d == 15'd0) return {1'b1, 1'b0, 11'h7FF};
    qq = nn / longint'(d);
    if (qq > 64'd2047) return {1'b0, 1'b1, 11'h7FF};
    return {2'b00, qq[10:0]};
  endfunction

  task automatic drive(input logic v, input logic [22:0] n, input logic [14:0] d, input logic [7:0] t);
    bus0.in_valid = v; bus0.numer = n; bus0.denom = d; bus0.in_tag = t;
    bus1.in_valid = v; bus1.numer = n; bus1.denom = d; bus1.in_tag = t;
  endtask

  task automatic set_en(input logic e);
    bus0.en = e;
    bus1.en = e;
  endtask

  task automatic sample();
    obs0 = {bus0.out_valid, bus0.div_zero, bus0.overflow, bus0.quotient, bus0.out_tag};
    obs1 = {bus1.out_valid, bus1.div_zero, bus1.overflow, bus1.quotient, bus1.out_tag};
  endtask

  // one isolated operation; early* is out_valid one cycle before the result is due
  task automatic run_one(input logic [22:0] n, input logic [14:0] d, input logic [7:0] t);
    @(negedge clock);
    drive(1'b1, n, d, t);
    @(negedge clock);
    drive(1'b0, 23'd0, 15'd0, 8'd0);
    repeat (12) @(negedge clock);
    early0 = bus0.out_valid;
    early1 = bus1.out_valid;
    @(negedge clock);
    sample();
  endtask

  task automatic test_reset();
    set_en(1'b1);
    drive(1'b0, 23'd0, 15'd0, 8'd0);
    aclr = 1'b0;
    #1 aclr = 1'b1;
    #1;
    sample();
    checks++;
    if ({obs0, obs1} !== 44'd0) begin
      failures++;
      $display("FAIL reset_state got=%h/%h exp=0/0", obs0, obs1);
    end
    @(negedge clock);
    aclr = 1'b0;
  endtask

  task automatic test_basic();
    run_one(23'd1005, 15'd9, 8'h01);
    checks++;
    if ({early0, early1} !== 2'b00) begin
      failures++;
      $display("FAIL basic_latency early_valid=%b%b exp=00", early0, early1);
    end
    checks++;
    if (obs0 !== {3'b100, 11'd111, 8'h01}) begin
      failures++;
      $display("FAIL basic_floor_1005_9 got=%h exp=%h", obs0, {3'b100, 11'd111, 8'h01});
    end
    checks++;
    if (obs1 !== {3'b100, 11'd112, 8'h01}) begin
      failures++;
      $display("FAIL basic_round_1005_9 got=%h exp=%h", obs1, {3'b100, 11'd112, 8'h01});
    end
    run_one(23'd1003, 15'd9, 8'h02);
    checks++;
    if ({obs0, obs1} !== {3'b100, 11'd111, 8'h02, 3'b100, 11'd111, 8'h02}) begin
      failures++;
      $display("FAIL basic_1003_9 got=%h/%h exp q=111/111", obs0, obs1);
    end
  endtask

  task automatic test_saturation();
    run_one(23'h7FFFFF, 15'd1, 8'h10);
    checks++;
    if ({obs0, obs1} !== {3'b101, 11'd2047, 8'h10, 3'b101, 11'd2047, 8'h10}) begin
      failures++;
      $display("FAIL sat_max_numer got=%h/%h exp=%h", obs0, obs1, {3'b101, 11'd2047, 8'h10});
    end
    run_one(23'd2047, 15'd1, 8'h11);
    checks++;
    if ({obs0, obs1} !== {3'b100, 11'd2047, 8'h11, 3'b100, 11'd2047, 8'h11}) begin
      failures++;
      $display("FAIL sat_2047_exact got=%h/%h exp=%h", obs0, obs1, {3'b100, 11'd2047, 8'h11});
    end
    run_one(23'd2048, 15'd1, 8'h12);
    checks++;
    if ({obs0, obs1} !== {3'b101, 11'd2047, 8'h12, 3'b101, 11'd2047, 8'h12}) begin
      failures++;
      $display("FAIL sat_2048 got=%h/%h exp=%h", obs0, obs1, {3'b101, 11'd2047, 8'h12});
    end
    // 18431/9 = 2047.9 fits; rounding pushes it to 2048.3 and saturates
    run_one(23'd18431, 15'd9, 8'h13);
    checks++;
    if ({obs0, obs1} !== {3'b100, 11'd2047, 8'h13, 3'b101, 11'd2047, 8'h13}) begin
      failures++;
      $display("FAIL sat_round_edge got=%h/%h exp=%h/%h", obs0, obs1, {3'b100, 11'd2047, 8'h13}, {3'b101, 11'd2047, 8'h13});
    end
    run_one(23'h7FFFFF, 15'h7FFF, 8'h14);
    checks++;
    if ({obs0, obs1} !== {3'b100, 11'd256, 8'h14, 3'b100, 11'd256, 8'h14}) begin
      failures++;
      $display("FAIL max_denom got=%h/%h exp=%h", obs0, obs1, {3'b100, 11'd256, 8'h14});
    end
  endtask

  task automatic test_div_zero();
    @(negedge clock);
    drive(1'b1, 23'd500, 15'd0, 8'h5A);
    @(negedge clock);
    drive(1'b1, 23'd20, 15'd3, 8'h11);
    @(negedge clock);
    drive(1'b0, 23'd0, 15'd0, 8'd0);
    repeat (11) @(negedge clock);
    checks++;
    if ({bus0.out_valid, bus1.out_valid} !== 2'b00) begin
      failures++;
      $display("FAIL dz_latency early_valid=%b%b exp=00", bus0.out_valid, bus1.out_valid);
    end
    @(negedge clock);
    sample();
    checks++;
    if ({obs0, obs1} !== {3'b110, 11'd2047, 8'h5A, 3'b110, 11'd2047, 8'h5A}) begin
      failures++;
      $display("FAIL dz_result got=%h/%h exp=%h", obs0, obs1, {3'b110, 11'd2047, 8'h5A});
    end
    @(negedge clock);
    sample();
    checks++;
    if ({obs0, obs1} !== {3'b100, 11'd6, 8'h11, 3'b100, 11'd7, 8'h11}) begin
      failures++;
      $display("FAIL dz_next_no_stall got=%h/%h exp=%h/%h", obs0, obs1, {3'b100, 11'd6, 8'h11}, {3'b100, 11'd7, 8'h11});
    end
    @(negedge clock);
    checks++;
    if ({bus0.out_valid, bus1.out_valid} !== 2'b00) begin
      failures++;
      $display("FAIL dz_single_output valid=%b%b exp=00", bus0.out_valid, bus1.out_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic [12:0] g0, g1;
    int idx;
    for (int i = 0; i < 100; i++) begin
      n_a[i] = 23'($urandom);
      if (i % 10 == 3) d_a[i] = 15'd0;
      else if (i % 7 == 0) d_a[i] = 15'($urandom_range(1, 4));
      else d_a[i] = 15'($urandom_range(1, 32767));
    end
    n_a[5] = 23'd0;
    for (int c = 0; c < 116; c++) begin
      @(negedge clock);
      idx = c - 14;
      sample();
      if (idx >= 0 && idx < 100) begin
        g0 = golden(n_a[idx], d_a[idx], 0);
        g1 = golden(n_a[idx], d_a[idx], 1);
        exp0 = {1'b1, g0, 8'(idx)};
        exp1 = {1'b1, g1, 8'(idx)};
        checks++;
        if ({obs0, obs1} !== {exp0, exp1}) begin
          failures++;
          $display("FAIL b2b_result idx=%0d n=%0d d=%0d got=%h/%h exp=%h/%h", idx, n_a[idx], d_a[idx], obs0, obs1, exp0, exp1);
        end
      end else begin
        checks++;
        if ({obs0[21], obs1[21]} !== 2'b00) begin
          failures++;
          $display("FAIL b2b_idle_valid cycle=%0d got=%b%b exp=00", c, obs0[21], obs1[21]);
        end
      end
      if (c < 100) drive(1'b1, n_a[c], d_a[c], 8'(c));
      else drive(1'b0, 23'd0, 15'd0, 8'd0);
    end
  endtask

  task automatic test_stall();
    int acc_e [12];
    int ecount, next_in, le, hit;
    logic en_now;
    logic [22:0] sn [12];
    logic [14:0] sd [12];
    for (int i = 0; i < 12; i++) begin
      acc_e[i] = -100;
      sn[i] = 23'(5000 + 997 * i);
      sd[i] = 15'(3 + 2 * i);
    end
    ecount = 0;
    next_in = 0;
    for (int c = 0; c < 46; c++) begin
      @(negedge clock);
      sample();
      le = ecount - 1;
      hit = -1;
      for (int i = 0; i < 12; i++) if (acc_e[i] == le - 13) hit = i;
      if (hit >= 0) begin
        exp0 = {1'b1, golden(sn[hit], sd[hit], 0), 8'(8'h80 + hit)};
        checks++;
        if (obs0 !== exp0) begin
          failures++;
          $display("FAIL stall_result cycle=%0d got=%h exp=%h", c, obs0, exp0);
        end
      end else begin
        checks++;
        if (obs0[21] !== 1'b0) begin
          failures++;
          $display("FAIL stall_idle_valid cycle=%0d got=%b exp=0", c, obs0[21]);
        end
      end
      en_now = !((c >= 5 && c <= 7) || (c >= 20 && c <= 22));
      set_en(en_now);
      if (!en_now) begin
        drive(1'(c), 23'h7FFFFF, 15'd1, 8'hEE);
      end else if (c == 10 || next_in >= 12) begin
        drive(1'b0, 23'd0, 15'd0, 8'd0);
      end else begin
        drive(1'b1, sn[next_in], sd[next_in], 8'(8'h80 + next_in));
        acc_e[next_in] = ecount;
        next_in++;
      end
      if (en_now) ecount++;
    end
    set_en(1'b1);
    drive(1'b0, 23'd0, 15'd0, 8'd0);
  endtask

  task automatic test_reset_midflight();
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      drive(1'b1, 23'(100 * (i + 1) + 1), 15'd7, 8'(8'h40 + i));
    end
    @(negedge clock);
    drive(1'b0, 23'd0, 15'd0, 8'd0);
    repeat (9) @(negedge clock);
    sample();
    checks++;
    if (obs0 !== {3'b100, 11'd14, 8'h40}) begin
      failures++;
      $display("FAIL rst_pre_result got=%h exp=%h", obs0, {3'b100, 11'd14, 8'h40});
    end
    #2 aclr = 1'b1;
    #1;
    sample();
    checks++;
    if ({obs0, obs1} !== 44'd0) begin
      failures++;
      $display("FAIL rst_async_clear got=%h/%h exp=0/0", obs0, obs1);
    end
    @(posedge clock);
    #3 aclr = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clock);
      checks++;
      if ({bus0.out_valid, bus1.out_valid} !== 2'b00) begin
        failures++;
        $display("FAIL rst_stale_output cycle=%0d got=%b%b exp=00", c, bus0.out_valid, bus1.out_valid);
      end
    end
    run_one(23'd701, 15'd7, 8'h55);
    checks++;
    if ({early0, early1} !== 2'b00) begin
      failures++;
      $display("FAIL rst_post_latency early_valid=%b%b exp=00", early0, early1);
    end
    checks++;
    if ({obs0, obs1} !== {3'b100, 11'd100, 8'h55, 3'b100, 11'd100, 8'h55}) begin
      failures++;
      $display("FAIL rst_post_result got=%h/%h exp=%h", obs0, obs1, {3'b100, 11'd100, 8'h55});
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_basic();
    test_saturation();
    test_div_zero();
    test_back_to_back();
    test_stall();
    test_reset_midflight();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
